// File: rtl/mmio_bus_pkg.sv
// Shared types for the MMIO bus: FSM states, write size codes and the latched request.
// Pure declarations; no logic.
package mmio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] WC_BYTE = 2'd0;
    localparam logic [1:0] WC_HALF = 2'd1;
    localparam logic [1:0] WC_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [1:0]  wc;
    } req_t;

    // Index width that stays at least one bit for a single-slave build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_bus_decoder.sv
// Priority address decoder: lowest-index slave whose masked window matches wins.
// Latency: combinational. Backpressure: none.
// Stateless; hit is low when no window matches.
module mmio_bus_decoder
    import mmio_bus_pkg::*;
#(
    parameter int                NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hFFFF_F000}}
) (
    input  logic [31:0]                  addr,
    output logic                         hit,
    output logic [idx_width(NSLV)-1:0]   idx
);

    localparam int IDXW = idx_width(NSLV);

    // Walk from the top down so the last match written is the lowest index.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                idx = i[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// Single-master MMIO bus: decodes, forwards to one slave, returns data or a bus error.
// Latency: hit = 2 cycles min (IDLE->WAIT->RESP), miss = 1 cycle; one access in flight.
// Backpressure: slave holds WAIT via s_ready; MMIO_BUS_TIMEOUT_EN bounds WAIT to TIMEOUT cycles.
module mmio_bus
    import mmio_bus_pkg::*;
#(
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hFFFF_F000}},
    parameter int                 TIMEOUT  = 255
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 m_req,
    input  logic [31:0]          m_Addr,
    input  logic                 m_WE,
    input  logic [31:0]          m_WD,
    input  logic [1:0]           m_WC,
    output logic                 m_ready,
    output logic [31:0]          m_RD,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_sel,
    output logic [NSLV-1:0]      s_WE,
    output logic [31:0]          s_Addr,
    output logic [31:0]          s_WD,
    output logic [1:0]           s_WC,
    input  logic [NSLV*32-1:0]   s_RD,
    input  logic [NSLV-1:0]      s_ready,
    output logic                 fault_irq,
    output logic [31:0]          fault_addr,
    input  logic                 fault_clr
);

    localparam int IDXW = idx_width(NSLV);

    state_e          state;
    req_t            lat;
    logic [IDXW-1:0] lat_idx;
    logic            dec_hit;
    logic [IDXW-1:0] dec_idx;
    logic            sel_rdy;
    logic [31:0]     sel_rd;
    logic            tmo;
    logic            fault_set;
    logic [31:0]     fault_at;

    mmio_bus_decoder #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (m_Addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign sel_rdy = s_ready[lat_idx];
    assign sel_rd  = s_RD[32*lat_idx +: 32];

`ifdef MMIO_BUS_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // wait_cnt holds the number of completed WAIT cycles, so TIMEOUT-1 marks the last one.
    assign tmo = (state == ST_WAIT) && (wait_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign m_ready = (state == ST_RESP);
    assign s_Addr  = lat.addr;
    assign s_WD    = lat.wd;
    assign s_WC    = lat.wc;

    always_comb begin
        s_sel = '0;
        if (state == ST_WAIT) begin
            s_sel[lat_idx] = 1'b1;
        end
        s_WE = s_sel & {NSLV{lat.we}};
    end

    // A slave completion in the timeout cycle takes priority over the abort.
    always_comb begin
        fault_set = 1'b0;
        fault_at  = lat.addr;
        if (state == ST_IDLE && m_req && !dec_hit) begin
            fault_set = 1'b1;
            fault_at  = m_Addr;
        end else if (state == ST_WAIT && !sel_rdy && tmo) begin
            fault_set = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            lat     <= '0;
            lat_idx <= '0;
            m_RD    <= '0;
            m_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_req) begin
                        lat     <= '{addr: m_Addr, we: m_WE, wd: m_WD, wc: m_WC};
                        lat_idx <= dec_idx;
                        m_RD    <= '0;
                        m_err   <= ~dec_hit;
                        state   <= dec_hit ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (sel_rdy) begin
                        m_RD  <= lat.we ? 32'h0 : sel_rd;
                        m_err <= 1'b0;
                        state <= ST_RESP;
                    end else if (tmo) begin
                        m_RD  <= '0;
                        m_err <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    m_RD  <= '0;
                    m_err <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            fault_irq  <= 1'b0;
            fault_addr <= '0;
        end else if (fault_set) begin
            fault_irq  <= 1'b1;
            fault_addr <= fault_at;
        end else if (fault_clr) begin
            fault_irq  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: reads, writes, decode miss, fault irq, overlap, timeout, reset abort.
// Slave 3 is configured with a wide window overlapping slave 1.
module tb_mmio_bus;
    import mmio_bus_pkg::*;

    localparam int NSLV = 4;

    logic              CLK;
    logic              reset;
    logic              m_req;
    logic [31:0]       m_Addr;
    logic              m_WE;
    logic [31:0]       m_WD;
    logic [1:0]        m_WC;
    logic              m_ready;
    logic [31:0]       m_RD;
    logic              m_err;
    logic [NSLV-1:0]   s_sel;
    logic [NSLV-1:0]   s_WE;
    logic [31:0]       s_Addr;
    logic [31:0]       s_WD;
    logic [1:0]        s_WC;
    logic [NSLV*32-1:0] s_RD;
    logic [NSLV-1:0]   s_ready;
    logic              fault_irq;
    logic [31:0]       fault_addr;
    logic              fault_clr;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_bus #(
        .NSLV     (NSLV),
        .SLV_BASE ({32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_1000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT  (4)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .m_req      (m_req),
        .m_Addr     (m_Addr),
        .m_WE       (m_WE),
        .m_WD       (m_WD),
        .m_WC       (m_WC),
        .m_ready    (m_ready),
        .m_RD       (m_RD),
        .m_err      (m_err),
        .s_sel      (s_sel),
        .s_WE       (s_WE),
        .s_Addr     (s_Addr),
        .s_WD       (s_WD),
        .s_WC       (s_WC),
        .s_RD       (s_RD),
        .s_ready    (s_ready),
        .fault_irq  (fault_irq),
        .fault_addr (fault_addr),
        .fault_clr  (fault_clr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        m_req     = 1'b0;
        m_Addr    = '0;
        m_WE      = 1'b0;
        m_WD      = '0;
        m_WC      = '0;
        fault_clr = 1'b0;
        s_ready   = '0;
        s_RD      = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_00AA};

        // Reset state
        #3;
        check("rst_m_ready", {31'd0, m_ready}, 32'd0);
        check("rst_s_sel", {28'd0, s_sel}, 32'd0);
        check("rst_m_RD", m_RD, 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        check("rst_fault_irq", {31'd0, fault_irq}, 32'd0);
        check("rst_s_Addr", s_Addr, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Read hit on slave 2, slave ready in first WAIT cycle
        m_req = 1'b1; m_Addr = 32'h0000_2004; m_WE = 1'b0; s_ready = 4'b0100;
        #1;
        check("idle_s_sel", {28'd0, s_sel}, 32'd0);
        tick();
        check("rd_wait_s_sel", {28'd0, s_sel}, 32'h4);
        check("rd_wait_s_WE", {28'd0, s_WE}, 32'h0);
        check("rd_wait_m_ready", {31'd0, m_ready}, 32'd0);
        check("rd_wait_s_Addr", s_Addr, 32'h0000_2004);
        m_Addr = 32'h0000_9999;
        tick();
        check("rd_resp_m_ready", {31'd0, m_ready}, 32'd1);
        check("rd_resp_m_RD", m_RD, 32'hDEAD_BEEF);
        check("rd_resp_m_err", {31'd0, m_err}, 32'd0);
        check("rd_resp_s_sel", {28'd0, s_sel}, 32'd0);
        check("rd_latched_addr", s_Addr, 32'h0000_2004);
        m_req = 1'b0; s_ready = '0;
        tick();
        check("rd_idle_m_ready", {31'd0, m_ready}, 32'd0);
        check("rd_idle_m_RD", m_RD, 32'd0);

        // Write to 0x1010: overlaps slaves 1 and 3, slave 1 must win; slave 3 ready ignored
        m_req = 1'b1; m_Addr = 32'h0000_1010; m_WE = 1'b1; m_WD = 32'h55; m_WC = WC_WORD;
        s_ready = 4'b1000;
        tick();
        check("wr_s_sel", {28'd0, s_sel}, 32'h2);
        check("wr_s_WE", {28'd0, s_WE}, 32'h2);
        check("wr_s_Addr", s_Addr, 32'h0000_1010);
        check("wr_s_WD", s_WD, 32'h55);
        check("wr_s_WC", {30'd0, s_WC}, 32'd2);
        tick();
        check("wr_unsel_rdy_ignored", {31'd0, m_ready}, 32'd0);
        check("wr_still_sel", {28'd0, s_sel}, 32'h2);
        s_ready = 4'b0010;
        tick();
        check("wr_resp_m_ready", {31'd0, m_ready}, 32'd1);
        check("wr_resp_m_RD", m_RD, 32'd0);
        check("wr_resp_m_err", {31'd0, m_err}, 32'd0);
        m_req = 1'b0; s_ready = '0; m_WE = 1'b0;
        tick();

        // Back-to-back: slave 3 only window, then slave 0 accepted right after RESP
        m_req = 1'b1; m_Addr = 32'h0000_3004; s_ready = 4'b1111;
        tick();
        check("b2b_s_sel3", {28'd0, s_sel}, 32'h8);
        tick();
        check("b2b_m_RD3", m_RD, 32'h3333_3333);
        m_Addr = 32'h0000_0008;
        tick();
        check("b2b_idle_m_ready", {31'd0, m_ready}, 32'd0);
        tick();
        check("b2b_s_sel0", {28'd0, s_sel}, 32'h1);
        tick();
        check("b2b_m_RD0", m_RD, 32'h0000_00AA);
        m_req = 1'b0; s_ready = '0;
        tick();

        // Decode miss
        m_req = 1'b1; m_Addr = 32'h8000_0000;
        tick();
        check("miss_m_ready", {31'd0, m_ready}, 32'd1);
        check("miss_m_err", {31'd0, m_err}, 32'd1);
        check("miss_m_RD", m_RD, 32'd0);
        check("miss_fault_irq", {31'd0, fault_irq}, 32'd1);
        check("miss_fault_addr", fault_addr, 32'h8000_0000);
        check("miss_s_sel", {28'd0, s_sel}, 32'd0);
        m_req = 1'b0;
        tick();
        check("irq_sticky", {31'd0, fault_irq}, 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("irq_cleared", {31'd0, fault_irq}, 32'd0);
        check("fault_addr_kept", fault_addr, 32'h8000_0000);

        // Fault and clear in the same cycle: fault wins
        m_req = 1'b1; m_Addr = 32'h9000_0000; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0; m_req = 1'b0;
        check("fault_beats_clr", {31'd0, fault_irq}, 32'd1);
        check("fault_addr_2", fault_addr, 32'h9000_0000);
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

`ifdef MMIO_BUS_TIMEOUT_EN
        // Slave 0 never ready: abort after 4 WAIT cycles
        m_req = 1'b1; m_Addr = 32'h0000_0000; s_ready = '0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("tmo_wait4_m_ready", {31'd0, m_ready}, 32'd0);
        check("tmo_wait4_s_sel", {28'd0, s_sel}, 32'h1);
        tick();
        check("tmo_m_ready", {31'd0, m_ready}, 32'd1);
        check("tmo_m_err", {31'd0, m_err}, 32'd1);
        check("tmo_fault_irq", {31'd0, fault_irq}, 32'd1);
        check("tmo_fault_addr", fault_addr, 32'h0);
        m_req = 1'b0;
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // s_ready in the 4th WAIT cycle beats the timeout
        m_req = 1'b1; m_Addr = 32'h0000_0000;
        tick();
        for (int i = 0; i < 3; i++) tick();
        s_ready = 4'b0001;
        tick();
        check("tmo_race_m_ready", {31'd0, m_ready}, 32'd1);
        check("tmo_race_m_err", {31'd0, m_err}, 32'd0);
        check("tmo_race_m_RD", m_RD, 32'h0000_00AA);
        check("tmo_race_irq", {31'd0, fault_irq}, 32'd0);
`else
        // Without the timeout, WAIT persists until the slave answers
        m_req = 1'b1; m_Addr = 32'h0000_0000; s_ready = '0;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("nowait_m_ready", {31'd0, m_ready}, 32'd0);
        check("nowait_s_sel", {28'd0, s_sel}, 32'h1);
        check("nowait_irq", {31'd0, fault_irq}, 32'd0);
        s_ready = 4'b0001;
        tick();
        check("nowait_resp", {31'd0, m_ready}, 32'd1);
        check("nowait_m_err", {31'd0, m_err}, 32'd0);
        check("nowait_m_RD", m_RD, 32'h0000_00AA);
`endif
        m_req = 1'b0; s_ready = '0;
        tick();

        // Reset during WAIT aborts the access
        m_req = 1'b1; m_Addr = 32'h0000_2000;
        tick();
        check("rstw_s_sel", {28'd0, s_sel}, 32'h4);
        #2;
        reset = 1'b0;
        #1;
        check("rstw_s_sel_cleared", {28'd0, s_sel}, 32'd0);
        check("rstw_m_ready", {31'd0, m_ready}, 32'd0);
        check("rstw_s_Addr", s_Addr, 32'd0);
        s_ready = 4'b0100;
        tick();
        check("rstw_no_pulse", {31'd0, m_ready}, 32'd0);
        reset = 1'b1;
        tick();
        check("rstw_retry_sel", {28'd0, s_sel}, 32'h4);
        tick();
        check("rstw_retry_ready", {31'd0, m_ready}, 32'd1);
        check("rstw_retry_RD", m_RD, 32'hDEAD_BEEF);
        m_req = 1'b0; s_ready = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
